// File: rtl/exponent_dispatcher.sv
// exponent_dispatcher: request FIFO and issue/capture sequencer
// in front of the exponent accelerator.
module exponent_dispatcher #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_x,
  input  logic [31:0]      req_a,
  input  logic [TAG_W-1:0] req_tag,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_p,
  output logic [TAG_W-1:0] res_tag,
  output logic [31:0]      res_cycles,
  output logic             acc_enable,
  output logic [31:0]      acc_x,
  output logic [31:0]      acc_a,
  input  logic             acc_ready,
  input  logic [31:0]      acc_p,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_LOW,
    WAIT_HIGH
  } state_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      a;
    logic [31:0]      x;
  } req_t;

  state_t           state, state_nx;
  req_t             mem [DEPTH];
  req_t             head;
  logic [AW:0]      wptr, rptr;
  logic             full, empty;
  logic             push, pop, capture;
  logic             slot_free;
  logic [TAG_W-1:0] hold_tag;
  logic [31:0]      cnt;

  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);
  assign head  = mem[rptr[AW-1:0]];
  assign push  = req_valid && !full;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      if (pop)        state_nx = ISSUE;
      ISSUE:                     state_nx = WAIT_LOW;
      WAIT_LOW:  if (!acc_ready) state_nx = WAIT_HIGH;
      WAIT_HIGH: if (acc_ready)  state_nx = IDLE;
      default:                   state_nx = IDLE;
    endcase
  end

  // Slot is free if empty or being drained this cycle.
  always_comb begin
    slot_free  = !res_valid || res_ready;
    pop        = (state == IDLE) && !empty &&
                 acc_ready && slot_free;
    capture    = (state == WAIT_HIGH) && acc_ready;
    acc_enable = (state == ISSUE);
    req_ready  = !full;
    busy       = (state != IDLE) || !empty;
  end

  always_ff @(posedge clock) begin
    if (push) mem[wptr[AW-1:0]] <= '{req_tag, req_a, req_x};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      acc_x    <= '0;
      acc_a    <= '0;
      hold_tag <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (pop) begin
        rptr     <= rptr + PTR_ONE;
        acc_x    <= head.x;
        acc_a    <= head.a;
        hold_tag <= head.tag;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (state == ISSUE) begin
      cnt <= 32'd1;
    end else if (state == WAIT_LOW ||
                 state == WAIT_HIGH) begin
      if (cnt != 32'hFFFF_FFFF) cnt <= cnt + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      res_valid  <= 1'b0;
      res_p      <= '0;
      res_tag    <= '0;
      res_cycles <= '0;
    end else if (capture) begin
      res_valid  <= 1'b1;
      res_p      <= acc_p;
      res_tag    <= hold_tag;
      res_cycles <= cnt;
    end else if (res_valid && res_ready) begin
      res_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exponent_dispatcher.sv
// Directed bench for exponent_dispatcher with a
// behavioural accelerator driven on the falling edge.
module tb_exponent_dispatcher;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_x;
  logic [31:0] req_a;
  logic [3:0]  req_tag;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_p;
  logic [3:0]  res_tag;
  logic [31:0] res_cycles;
  logic        acc_enable;
  logic [31:0] acc_x;
  logic [31:0] acc_a;
  logic        acc_ready;
  logic [31:0] acc_p;
  logic        busy;

  int   checks = 0;
  int   errors = 0;
  int   en_cnt = 0;
  logic prev_en = 1'b0;

  logic        mrdy = 1'b1;
  logic        hold = 1'b0;
  int          mcnt = 0;
  logic [31:0] mp   = '0;

  exponent_dispatcher #(.DEPTH(4), .TAG_W(4)) dut (
    .clock(clock),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_x(req_x),
    .req_a(req_a),
    .req_tag(req_tag),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_p(res_p),
    .res_tag(res_tag),
    .res_cycles(res_cycles),
    .acc_enable(acc_enable),
    .acc_x(acc_x),
    .acc_a(acc_a),
    .acc_ready(acc_ready),
    .acc_p(acc_p),
    .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] pow32(
    input logic [31:0] x, input logic [31:0] a);
    logic [31:0] r = 32'd1;
    for (int i = 0; i < int'(a); i++) r = r * x;
    return r;
  endfunction

  // Accelerator: ready drops after the start pulse,
  // product valid only on the cycle ready returns.
  assign acc_ready = mrdy && !hold;
  initial acc_p = 32'hDEAD_BEEF;
  always @(negedge clock) begin
    if (acc_enable === 1'b1) begin
      mrdy  <= 1'b0;
      mcnt  <= int'(acc_a) + 3;
      mp    <= pow32(acc_x, acc_a);
      acc_p <= 32'hDEAD_BEEF;
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) begin
        mrdy  <= 1'b1;
        acc_p <= mp;
      end else begin
        acc_p <= 32'hDEAD_BEEF;
      end
    end else begin
      acc_p <= 32'hDEAD_BEEF;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    if (acc_enable === 1'b1) begin
      checks++;
      assert (prev_en !== 1'b1) else begin
        errors++;
        $error("FAIL en_pulse observed 1 expected 0");
      end
    end
    prev_en = acc_enable;
    en_cnt += int'(acc_enable);
  endtask

  task automatic push(input logic [31:0] x,
                      input logic [31:0] a,
                      input logic [3:0]  t);
    req_x     = x;
    req_a     = a;
    req_tag   = t;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_res(input logic [31:0] p,
                          input logic [3:0]  t,
                          input logic [31:0] cyc,
                          input string name);
    int n = 0;
    while (res_valid !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    chk({name, "_valid"}, 32'(res_valid), 32'd1);
    chk({name, "_p"}, res_p, p);
    chk({name, "_tag"}, 32'(res_tag), 32'(t));
    chk({name, "_cyc"}, res_cycles, cyc);
    tick();
  endtask

  task automatic chk_reset(input string name);
    chk({name, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({name, "_res_valid"}, 32'(res_valid), 32'd0);
    chk({name, "_res_p"}, res_p, 32'd0);
    chk({name, "_res_tag"}, 32'(res_tag), 32'd0);
    chk({name, "_res_cyc"}, res_cycles, 32'd0);
    chk({name, "_acc_en"}, 32'(acc_enable), 32'd0);
    chk({name, "_acc_x"}, acc_x, 32'd0);
    chk({name, "_acc_a"}, acc_a, 32'd0);
    chk({name, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int   n;
    logic seen;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_x     = '0;
    req_a     = '0;
    req_tag   = '0;
    res_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk_reset("rst");

    // basic: 3^4 = 81, a+3 = 7 cycles
    res_ready = 1'b1;
    en_cnt = 0;
    push(32'd3, 32'd4, 4'd5);
    chk("lat_early", 32'(acc_enable), 32'd0);
    tick();
    chk("lat_en", 32'(acc_enable), 32'd1);
    chk("lat_x", acc_x, 32'd3);
    chk("lat_a", acc_a, 32'd4);
    wait_res(32'd81, 4'd5, 32'd7, "basic");
    chk("basic_en_cnt", 32'(en_cnt), 32'd1);
    chk("basic_pop", 32'(res_valid), 32'd0);

    // zero exponent
    push(32'd9, 32'd0, 4'd1);
    wait_res(32'd1, 4'd1, 32'd3, "zero");

    // fill, overflow attempt, drain in order; three rounds wrap
    for (int r = 0; r < 3; r++) begin
      hold = 1'b1;
      tick();
      en_cnt = 0;
      for (int i = 0; i < 4; i++) begin
        chk("fill_ready", 32'(req_ready), 32'd1);
        req_x     = 32'(2 + i + r);
        req_a     = 32'(i + 1);
        req_tag   = 4'(i);
        req_valid = 1'b1;
        tick();
      end
      req_x   = 32'd99;
      req_a   = 32'd1;
      req_tag = 4'd15;
      chk("full_ready", 32'(req_ready), 32'd0);
      tick();
      req_valid = 1'b0;
      chk("full_busy", 32'(busy), 32'd1);
      chk("full_no_en", 32'(en_cnt), 32'd0);
      hold = 1'b0;
      for (int i = 0; i < 4; i++)
        wait_res(pow32(32'(2 + i + r), 32'(i + 1)),
                 4'(i), 32'(i + 4), "order");
      tick();
      chk("drain_busy", 32'(busy), 32'd0);
    end

    // result backpressure
    res_ready = 1'b0;
    push(32'd5, 32'd2, 4'd7);
    push(32'd7, 32'd1, 4'd8);
    wait_res(32'd25, 4'd7, 32'd5, "bp1");
    en_cnt = 0;
    repeat (15) tick();
    chk("bp_hold_valid", 32'(res_valid), 32'd1);
    chk("bp_hold_p", res_p, 32'd25);
    chk("bp_hold_tag", 32'(res_tag), 32'd7);
    chk("bp_no_en", 32'(en_cnt), 32'd0);
    res_ready = 1'b1;
    tick();
    chk("bp_issue", 32'(acc_enable), 32'd1);
    chk("bp_issue_x", acc_x, 32'd7);
    chk("bp_popped", 32'(res_valid), 32'd0);
    wait_res(32'd7, 4'd8, 32'd4, "bp2");

    // reset while waiting on a long job
    push(32'd3, 32'd10, 4'd2);
    n = 0;
    while (acc_enable !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("mid_issue", 32'(acc_enable), 32'd1);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    chk_reset("mid_rst");
    reset = 1'b0;
    seen = 1'b0;
    repeat (25) begin
      tick();
      if (res_valid === 1'b1) seen = 1'b1;
    end
    chk("mid_no_res", 32'(seen), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_ready", 32'(req_ready), 32'd1);

    // accelerator not ready after reset
    hold  = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    push(32'd4, 32'd3, 4'd9);
    en_cnt = 0;
    repeat (10) tick();
    chk("nr_no_en", 32'(en_cnt), 32'd0);
    chk("nr_busy", 32'(busy), 32'd1);
    hold = 1'b0;
    tick();
    chk("nr_issue", 32'(acc_enable), 32'd1);
    wait_res(32'd64, 4'd9, 32'd6, "nr");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exponent_dispatcher.md
# exponent_dispatcher

Front-end stage that feeds the exponent accelerator. It buffers exponentiation requests (base x, exponent a, tag) in a small FIFO and issues them one at a time over the accelerator's enable/ready handshake. It captures each result and presents it in order, with its tag and a cycle count, on a valid/ready result port. It sits between the system controller and the accelerator, so the controller never has to track accelerator timing.

## Interface
- DEPTH, 4: request FIFO entries; power of two, ≥2.
- TAG_W, 4: request tag width.

- clock  input  1  rising-edge clock for all state.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  FIFO can accept; equals !full.
- req_x  input  32  base.
- req_a  input  32  exponent.
- req_tag  input  TAG_W  caller tag, returned with result.
- res_valid  output  1  result slot full.
- res_ready  input  1  consumer accepts result.
- res_p  output  32  x^a mod 2^32.
- res_tag  output  TAG_W  tag of the result.
- res_cycles  output  32  cycles from issue to capture, saturating.
- acc_enable  output  1  single-cycle start pulse to accelerator.
- acc_x  output  32  base to accelerator, held stable from issue to capture.
- acc_a  output  32  exponent to accelerator, held stable from issue to capture.
- acc_ready  input  1  accelerator idle/done indicator.
- acc_p  input  32  accelerator product.
- busy  output  1  state != IDLE or FIFO non-empty.

## Operation
- Request push: occurs when req_valid && req_ready. No push while full (req_ready=0); a push and a pop in the same cycle are both allowed when the FIFO is not full. Pointers are log2(DEPTH)+1 bits; full/empty come from the MSB compare, and pointers wrap naturally.
- States:
  - IDLE -> ISSUE when the FIFO is non-empty, acc_ready=1, and the result slot is free. The slot counts as free if res_valid=0 or res_ready=1 this cycle. On this transition the FIFO head is popped into acc_x, acc_a and a held tag register.
  - ISSUE: acc_enable=1 for exactly this cycle. res_cycles counter is cleared to 1. Always -> WAIT_LOW.
  - WAIT_LOW: stays while acc_ready=1; -> WAIT_HIGH on acc_ready=0.
  - WAIT_HIGH: stays while acc_ready=0; on acc_ready=1, captures acc_p into res_p, the held tag into res_tag and the counter into res_cycles, sets res_valid, and goes -> IDLE.
- The counter increments every cycle in WAIT_LOW/WAIT_HIGH and saturates at 32'hFFFFFFFF.
- Result slot: res_valid clears on res_valid && res_ready unless a capture happens in the same cycle; a capture has priority and the slot stays valid. Because of the IDLE issue condition, no capture can occur while an unconsumed result is held.
- acc_p is sampled only on the first acc_ready=1 cycle in WAIT_HIGH; the accelerator's product is valid in that cycle only.
- acc_ready rising while in IDLE (e.g. stale completion after a dispatcher-only reset) is ignored.
- Exponent a=0 is legal; the accelerator returns 1 and it is passed through unchanged.

## Timing
- Reset values: state=IDLE, FIFO empty, req_ready=1, res_valid=0, res_p=0, res_tag=0, res_cycles=0, acc_enable=0, acc_x=0, acc_a=0, busy=0.
- Reset mid-operation: all of the above apply on the next edge. Any in-flight job is dropped and never produces res_valid. After reset, no issue occurs until acc_ready is sampled 1 in IDLE.
- Request to acc_enable: minimum 2 cycles (push edge, then IDLE sees non-empty, then the ISSUE cycle).
- Accelerator turnaround: acc_ready falls the cycle after ISSUE and rises a+3 cycles after ISSUE. res_valid rises the cycle after that rise, giving res_cycles = a+3.
- Back-to-back jobs: next ISSUE occurs no earlier than 1 cycle after capture (IDLE cycle).
- acc_enable is never high in two consecutive cycles, and never high outside ISSUE.

## Test plan
- Basic: push x=3, a=4, tag=5 with res_ready=1 -> one acc_enable pulse; res_valid with res_p=81, res_tag=5, res_cycles=7.
- Zero exponent: push x=9, a=0, tag=1 -> res_p=1, res_cycles=3.
- FIFO full: push 5 requests back-to-back while acc_ready is held 0 -> 4 accepted, then req_ready=0 on the 5th. Release acc_ready -> results return in push order, tags 0..3. Wrap: repeat twice more with correct ordering.
- Result backpressure: res_ready=0 with two jobs queued -> first result is held and stable; no second acc_enable. Raise res_ready -> slot pops and the second issue follows.
- Reset in WAIT_HIGH: assert reset for 1 cycle during a=10 job -> all outputs at reset values. The later acc_ready rise produces no res_valid, and the FIFO is empty.
- Accelerator not ready: acc_ready=0 after reset with a queued request -> acc_enable stays 0 until acc_ready=1, then pulses the next cycle.
